// File: rtl/mac_pkg.sv
// mac_pkg: shared types and constants for the memory access controller.
//   state_e     - controller states (IDLE, BUSY, DONE)
//   PORT_*      - requester indices used by the arbiter and the grant register
//   RW_*        - RAM read/write encoding
//   is_write()  - helper that decodes the RW encoding
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic is_write(input logic rw);
    return rw == RW_WRITE;
  endfunction

endpackage

// File: rtl/mac_arbiter.sv
// mac_arbiter: two-way round-robin arbiter between the fetch and data ports.
//   clk, rst       - clock and asynchronous active-high reset
//   en             - grant only when the controller is idle
//   f_req, d_req   - raw request lines
//   gnt_valid_c    - combinational: a grant is issued this cycle
//   gnt_port_c     - combinational: winning port (PORT_FETCH / PORT_DATA)
// last_grant resets to the data port so that the first tie goes to fetch.
module mac_arbiter
  import mac_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic f_req,
  input  logic d_req,
  output logic gnt_valid_c,
  output logic gnt_port_c
);

  logic last_grant_q;
  logic last_grant_d;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    gnt_valid_c = en && (f_req || d_req);
    gnt_port_c  = PORT_FETCH;
    if (f_req && d_req) begin
      gnt_port_c = (last_grant_q == PORT_DATA) ? PORT_FETCH : PORT_DATA;
    end else if (d_req) begin
      gnt_port_c = PORT_DATA;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_valid_c) begin
      last_grant_d = gnt_port_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_DATA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: sequences RAM transactions for the fetch and data
// requesters, waits for MOC and returns a one-cycle ack with read data.
//   Clk, Clr                      - clock, asynchronous active-high reset
//   f_req, f_addr, f_ack          - fetch port (always a read)
//   d_req, d_rw, d_addr, d_wdata, d_ack - data port
//   rdata, err                    - read data and timeout flag, valid with ack
//   busy                          - controller not idle
//   MOV, RW, mem_addr, mem_wdata, mem_rdata, MOC - RAM handshake
// Build option: define MAC_TIMEOUT_EN to abandon a BUSY cycle after WAIT_MAX
// cycles without MOC and flag err; otherwise BUSY waits forever, err is 0.
module mem_access_controller
  import mac_pkg::*;
#(
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              MOV,
  output logic              RW,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              MOC
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("WAIT_MAX must be in 1..255");
  end

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              mov_q, mov_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              busy_q, busy_d;

  logic gnt_valid_c;
  logic gnt_port_c;

`ifdef MAC_TIMEOUT_EN
  localparam int unsigned      CNT_W      = 8;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
`endif

  mac_arbiter u_arbiter (
    .clk        (Clk),
    .rst        (Clr),
    .en         (state_q == IDLE),
    .f_req      (f_req),
    .d_req      (d_req),
    .gnt_valid_c(gnt_valid_c),
    .gnt_port_c (gnt_port_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    mov_d   = mov_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f_ack_d = 1'b0;
    d_ack_d = 1'b0;
`ifdef MAC_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          grant_d = gnt_port_c;
          mov_d   = 1'b1;
          state_d = BUSY;
`ifdef MAC_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
          if (gnt_port_c == PORT_DATA) begin
            rw_d   = d_rw;
            addr_d = d_addr;
            // RAM data lines only move for writes.
            if (is_write(d_rw)) begin
              wdata_d = d_wdata;
            end
          end else begin
            rw_d   = RW_READ;
            addr_d = f_addr;
          end
        end
      end

      BUSY: begin
        if (MOC) begin
          rdata_d = mem_rdata;
          mov_d   = 1'b0;
          state_d = DONE;
          f_ack_d = (grant_q == PORT_FETCH);
          d_ack_d = (grant_q == PORT_DATA);
`ifdef MAC_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end
`ifdef MAC_TIMEOUT_EN
        // MOC takes priority over the limit on the same edge.
        else if (wait_cnt_q == WAIT_LIMIT) begin
          mov_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          f_ack_d = (grant_q == PORT_FETCH);
          d_ack_d = (grant_q == PORT_DATA);
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        mov_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= IDLE;
      grant_q <= PORT_FETCH;
      mov_q   <= 1'b0;
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      mov_q   <= mov_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f_ack_q <= f_ack_d;
      d_ack_q <= d_ack_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MAC_TIMEOUT_EN
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign MOV       = mov_q;
  assign RW        = rw_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign f_ack     = f_ack_q;
  assign d_ack     = d_ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: directed and randomized transactions checked
// against a transaction-level model (round-robin grant, expected RAM lines,
// ack port, read data, err). Timeout cases run only with MAC_TIMEOUT_EN.
module tb_mem_access_controller;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WAIT_MAX = 15;

  logic              Clk = 1'b0;
  logic              Clr;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic              d_req;
  logic              d_rw;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic              MOV;
  logic              RW;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              MOC;

  mem_access_controller #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .Clk      (Clk),
    .Clr      (Clr),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_ack    (f_ack),
    .d_req    (d_req),
    .d_rw     (d_rw),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .rdata    (rdata),
    .err      (err),
    .busy     (busy),
    .MOV      (MOV),
    .RW       (RW),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .MOC      (MOC)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: 0 = fetch won last, 1 = data won last.
  bit                last_grant_m;
  logic [DATA_W-1:0] rdata_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic raise_f(input logic [ADDR_W-1:0] a);
    f_req  = 1'b1;
    f_addr = a;
  endtask

  task automatic raise_d(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    d_req   = 1'b1;
    d_rw    = rw;
    d_addr  = a;
    d_wdata = wd;
  endtask

  // Entered in IDLE (#1 after an edge) with at least one request raised.
  // delay = BUSY cycles without MOC before the MOC edge.
  task automatic run_txn(input int delay_in, input logic [DATA_W-1:0] rd);
    bit                g;
    bit                tmo;
    int                delay;
    logic              exp_rw;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wd;
    logic [DATA_W-1:0] exp_rd;
    delay = delay_in;
    tmo   = 1'b0;
    if (f_req && d_req) g = !last_grant_m;
    else                g = d_req;
    last_grant_m = g;
    exp_rw   = g ? d_rw : 1'b1;
    exp_addr = g ? d_addr : f_addr;
    exp_wd   = d_wdata;
`ifdef MAC_TIMEOUT_EN
    if (delay > int'(WAIT_MAX)) begin
      tmo   = 1'b1;
      delay = int'(WAIT_MAX);
    end
`endif
    tick();
    for (int k = 0; k <= delay; k++) begin
      check("mov_busy", {62'd0, MOV, busy}, 64'h3);
      check("rw", RW, exp_rw);
      check("addr", mem_addr, exp_addr);
      if (g && !exp_rw) check("wdata", mem_wdata, exp_wd);
      check("no_ack_busy", {62'd0, f_ack, d_ack}, 64'h0);
      if (k == delay) begin
        MOC       = !tmo;
        mem_rdata = rd;
      end else begin
        MOC       = 1'b0;
        mem_rdata = $urandom;
      end
      tick();
    end
    MOC    = 1'b0;
    exp_rd = tmo ? rdata_m : rd;
    check("f_ack", f_ack, !g);
    check("d_ack", d_ack, g);
    check("err", err, tmo);
    check("rdata", rdata, exp_rd);
    check("mov_done", MOV, 1'b0);
    rdata_m = exp_rd;
    if (g) d_req = 1'b0;
    else   f_req = 1'b0;
    tick();
    check("idle_gap", {61'd0, f_ack, d_ack, busy | MOV}, 64'h0);
  endtask

  initial begin
    Clr = 1'b1; f_req = 1'b0; d_req = 1'b0; d_rw = 1'b1;
    f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; MOC = 1'b0;
    last_grant_m = 1'b1;
    rdata_m      = '0;
    tick(); tick();
    check("rst_mov_rw", {62'd0, MOV, RW}, 64'h1);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_flags", {60'd0, f_ack, d_ack, err, busy}, 64'h0);
    Clr = 1'b0;
    tick();

    // Single fetch, MOC one cycle after MOV.
    raise_f(9'h004);
    run_txn(0, 32'hDEADBEEF);

    // Data write with MOC delayed three cycles.
    raise_d(1'b0, 9'h010, 32'h12345678);
    run_txn(3, 32'h0BAD_F00D);

    // Both ports held across three grants: fetch, data, fetch.
    raise_f(9'h020);
    raise_d(1'b1, 9'h030, 32'h0);
    run_txn(1, 32'h1111_1111);
    raise_f(9'h021);
    run_txn(0, 32'h2222_2222);
    raise_d(1'b0, 9'h031, 32'hCAFE_0001);
    run_txn(2, 32'h3333_3333);
    run_txn(0, 32'h4444_4444);

    // MOC glitch in IDLE must not start or complete anything.
    MOC = 1'b1;
    tick();
    MOC = 1'b0;
    check("glitch1", {60'd0, f_ack, d_ack, busy, MOV}, 64'h0);
    tick();
    check("glitch2", {60'd0, f_ack, d_ack, busy, MOV}, 64'h0);

    // Clr mid-BUSY abandons the transaction and resets last_grant.
    raise_d(1'b1, 9'h055, 32'h0);
    tick();
    check("pre_clr_mov", MOV, 1'b1);
    #2 Clr = 1'b1;
    #1;
    check("clr_async", {60'd0, f_ack, d_ack, busy, MOV}, 64'h0);
    d_req = 1'b0;
    tick();
    Clr = 1'b0;
    last_grant_m = 1'b1;
    rdata_m      = '0;
    check("clr_rdata", rdata, 0);
    tick();
    check("clr_no_ack", {60'd0, f_ack, d_ack, busy, MOV}, 64'h0);
    raise_f(9'h0A0);
    raise_d(1'b1, 9'h0B0, 32'h0);
    run_txn(0, 32'h5555_5555);
    run_txn(0, 32'h6666_6666);

`ifdef MAC_TIMEOUT_EN
    // No MOC at all: timeout with err; then MOC exactly on the limit edge.
    raise_f(9'h1F0);
    run_txn(20, 32'h7777_7777);
    raise_d(1'b1, 9'h1F1, 32'h0);
    run_txn(int'(WAIT_MAX), 32'h8888_8888);
`endif

    // Randomized traffic with pending requests carried between transactions.
    for (int i = 0; i < 60; i++) begin
      if (!f_req && $urandom_range(0, 1) == 1) raise_f(ADDR_W'($urandom));
      if (!d_req && $urandom_range(0, 1) == 1)
        raise_d(1'($urandom), ADDR_W'($urandom), $urandom);
      if (!f_req && !d_req) raise_f(ADDR_W'($urandom));
      run_txn(int'($urandom_range(0, 4)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
